// File: rtl/iaaa_pkg.sv
// Shared encodings for the IAAA control path: opcodes, register and bus codes,
// ALU operations, sequencer states and the control word layout.
package iaaa_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LDAC = 4'd1;
   localparam logic [3:0] OP_STAC = 4'd2;
   localparam logic [3:0] OP_MVR  = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_SUB  = 4'd5;
   localparam logic [3:0] OP_INC  = 4'd6;
   localparam logic [3:0] OP_JPNZ = 4'd7;
   localparam logic [3:0] OP_JMP  = 4'd8;
   localparam logic [3:0] OP_END  = 4'd15;

   localparam logic [4:0] REG_PC   = 5'd0;
   localparam logic [4:0] REG_AR   = 5'd1;
   localparam logic [4:0] REG_AC   = 5'd2;
   localparam logic [4:0] REG_R    = 5'd3;
   localparam logic [4:0] REG_MIDR = 5'd18;
   localparam logic [4:0] REG_IR   = 5'd19;
   localparam logic [4:0] REG_ALL  = 5'd31;

   localparam logic [3:0] RD_PC   = 4'd0;
   localparam logic [3:0] RD_AR   = 4'd1;
   localparam logic [3:0] RD_AC   = 4'd2;
   localparam logic [3:0] RD_R    = 4'd3;
   localparam logic [3:0] RD_MIDR = 4'd4;
   localparam logic [3:0] RD_ALU  = 4'd5;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_INC  = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_F1   = 3'd1,
      ST_F2   = 3'd2,
      ST_F3   = 3'd3,
      ST_DEC  = 3'd4,
      ST_EXEC = 3'd5,
      ST_HALT = 3'd6
   } state_t;

   typedef struct packed {
      logic       wr_en;
      logic [4:0] wr_code;
      logic [3:0] rd_sel;
      logic [2:0] alu_op;
      logic       pc_inc;
      logic       mem_rd;
      logic       mem_wr;
      logic       done;
      logic       illegal;
   } ctrl_word_t;

   // Index of the final exec step; opcodes without exec steps never reach EXEC.
   function automatic logic [1:0] last_step(input logic [3:0] op);
      case (op)
         OP_LDAC: last_step = 2'd2;
         OP_STAC: last_step = 2'd1;
         default: last_step = 2'd0;
      endcase
   endfunction

   function automatic logic is_undef(input logic [3:0] op);
      is_undef = (op >= 4'd9) && (op <= 4'd14);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode from sequencer state, exec step, opcode and Z.
// IAAA_ILLEGAL_TRAP_EN enables the Illegal flag while halted on an undefined opcode.
module ctrl_decode
   import iaaa_pkg::*;
(
   input  state_t     state,
   input  logic [1:0] step,
   input  logic [3:0] op,
   input  logic       z,
   output ctrl_word_t cw
);

   always_comb begin
      cw = '0;
      case (state)
         ST_F1: begin
            cw.rd_sel  = RD_PC;
            cw.wr_en   = 1'b1;
            cw.wr_code = REG_AR;
            cw.pc_inc  = 1'b1;
         end
         ST_F2: cw.mem_rd = 1'b1;
         ST_F3: begin
            cw.rd_sel  = RD_MIDR;
            cw.wr_en   = 1'b1;
            cw.wr_code = REG_IR;
         end
         ST_EXEC: begin
            case (op)
               OP_LDAC: begin
                  case (step)
                     2'd0: begin
                        cw.rd_sel  = RD_R;
                        cw.wr_en   = 1'b1;
                        cw.wr_code = REG_AR;
                     end
                     2'd1: cw.mem_rd = 1'b1;
                     2'd2: begin
                        cw.rd_sel  = RD_MIDR;
                        cw.wr_en   = 1'b1;
                        cw.wr_code = REG_AC;
                     end
                     default: cw = '0;
                  endcase
               end
               OP_STAC: begin
                  case (step)
                     2'd0: begin
                        cw.rd_sel  = RD_R;
                        cw.wr_en   = 1'b1;
                        cw.wr_code = REG_AR;
                     end
                     2'd1: begin
                        cw.rd_sel = RD_AC;
                        cw.mem_wr = 1'b1;
                     end
                     default: cw = '0;
                  endcase
               end
               OP_MVR: begin
                  cw.rd_sel  = RD_AC;
                  cw.wr_en   = 1'b1;
                  cw.wr_code = REG_R;
               end
               OP_ADD, OP_SUB, OP_INC: begin
                  cw.rd_sel  = RD_ALU;
                  cw.alu_op  = (op == OP_ADD) ? ALU_ADD :
                               (op == OP_SUB) ? ALU_SUB : ALU_INC;
                  cw.wr_en   = 1'b1;
                  cw.wr_code = REG_AC;
               end
               OP_JMP: begin
                  cw.rd_sel  = RD_R;
                  cw.wr_en   = 1'b1;
                  cw.wr_code = REG_PC;
               end
               OP_JPNZ: begin
                  if (!z) begin
                     cw.rd_sel  = RD_R;
                     cw.wr_en   = 1'b1;
                     cw.wr_code = REG_PC;
                  end
               end
               default: cw = '0;
            endcase
         end
         ST_HALT: begin
            cw.done = 1'b1;
`ifdef IAAA_ILLEGAL_TRAP_EN
            // IR is not reloaded while halted, so the trapping opcode is still visible.
            cw.illegal = is_undef(op);
`endif
         end
         default: cw = '0;
      endcase
   end

endmodule

// File: rtl/ctrl_unit.sv
// IAAA fetch/decode/execute sequencer: holds state and exec step, decode is in ctrl_decode.
// IAAA_ILLEGAL_TRAP_EN makes opcodes 9-14 halt with Illegal instead of running as NOP.
module ctrl_unit
   import iaaa_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       Start,
   input  logic [3:0] IR_out,
   input  logic       Z,
   output logic       WR_en,
   output logic [4:0] WR_code,
   output logic [3:0] RD_sel,
   output logic [2:0] ALU_op,
   output logic       PC_inc,
   output logic       Mem_rd,
   output logic       Mem_wr,
   output logic       Done,
   output logic       Illegal
);

   state_t     state, state_nxt;
   logic [1:0] step, step_nxt;
   ctrl_word_t cw;

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      case (state)
         ST_IDLE: if (Start) state_nxt = ST_F1;
         ST_F1:   state_nxt = ST_F2;
         ST_F2:   state_nxt = ST_F3;
         ST_F3:   state_nxt = ST_DEC;
         ST_DEC: begin
            step_nxt = 2'd0;
            if (IR_out == OP_END)
               state_nxt = ST_HALT;
`ifdef IAAA_ILLEGAL_TRAP_EN
            else if (is_undef(IR_out))
               state_nxt = ST_HALT;
            else if (IR_out == OP_NOP)
               state_nxt = ST_F1;
`else
            else if (IR_out == OP_NOP || is_undef(IR_out))
               state_nxt = ST_F1;
`endif
            else
               state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            if (step == last_step(IR_out)) begin
               state_nxt = ST_F1;
               step_nxt  = 2'd0;
            end else begin
               step_nxt = step + 2'd1;
            end
         end
         ST_HALT: if (Start) state_nxt = ST_F1;
         default: begin
            state_nxt = ST_IDLE;
            step_nxt  = 2'd0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_IDLE;
         step  <= 2'd0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
      end
   end

   ctrl_decode u_decode (
      .state (state),
      .step  (step),
      .op    (IR_out),
      .z     (Z),
      .cw    (cw)
   );

   assign WR_en   = cw.wr_en;
   assign WR_code = cw.wr_code;
   assign RD_sel  = cw.rd_sel;
   assign ALU_op  = cw.alu_op;
   assign PC_inc  = cw.pc_inc;
   assign Mem_rd  = cw.mem_rd;
   assign Mem_wr  = cw.mem_wr;
   assign Done    = cw.done;
   assign Illegal = cw.illegal;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed table-driven bench for ctrl_unit plus hand-written reset and halt sequences.
module tb_ctrl_unit;
   import iaaa_pkg::*;

   logic       Clock, Reset_n, Start, Z;
   logic [3:0] IR_out;
   logic       WR_en, PC_inc, Mem_rd, Mem_wr, Done, Illegal;
   logic [4:0] WR_code;
   logic [3:0] RD_sel;
   logic [2:0] ALU_op;

   ctrl_unit dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .Start   (Start),
      .IR_out  (IR_out),
      .Z       (Z),
      .WR_en   (WR_en),
      .WR_code (WR_code),
      .RD_sel  (RD_sel),
      .ALU_op  (ALU_op),
      .PC_inc  (PC_inc),
      .Mem_rd  (Mem_rd),
      .Mem_wr  (Mem_wr),
      .Done    (Done),
      .Illegal (Illegal)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic        start;
      logic [3:0]  ir;
      logic        z;
      logic [17:0] exp;
      string       name;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   fails  = 0;

   logic [17:0] w_zero, w_f1, w_f2, w_f3, w_done;

   function automatic logic [17:0] mk(input logic wr, input logic [4:0] code,
                                      input logic [3:0] rd, input logic [2:0] alu,
                                      input logic pc, input logic mr, input logic mw,
                                      input logic dn, input logic il);
      mk = {wr, code, rd, alu, pc, mr, mw, dn, il};
   endfunction

   function automatic logic [17:0] outs();
      outs = {WR_en, WR_code, RD_sel, ALU_op, PC_inc, Mem_rd, Mem_wr, Done, Illegal};
   endfunction

   task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got=%05h expected=%05h", name, got, exp);
      end
   endtask

   task automatic add(input logic s, input logic [3:0] ir, input logic z,
                      input logic [17:0] exp, input string name);
      vec_t v;
      v.start = s; v.ir = ir; v.z = z; v.exp = exp; v.name = name;
      vq.push_back(v);
   endtask

   // F1, F2, F3 with the previous opcode still sitting in the IR.
   task automatic add_fetch(input logic [3:0] ir, input logic start_f2);
      add(1'b0, ir, 1'b0, w_f1, "f1");
      add(start_f2, ir, 1'b0, w_f2, "f2");
      add(1'b0, ir, 1'b0, w_f3, "f3");
   endtask

   initial begin
      int cyc;
      logic seen;

      w_zero = '0;
      w_f1   = mk(1'b1, 5'd1, RD_PC, ALU_PASS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      w_f2   = mk(1'b0, 5'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      w_f3   = mk(1'b1, 5'd19, RD_MIDR, ALU_PASS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      w_done = mk(1'b0, 5'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      add(1'b0, 4'd0, 1'b0, w_zero, "idle");
      add(1'b1, 4'd0, 1'b0, w_zero, "idle_start");
      add_fetch(4'd0, 1'b0);
      add(1'b0, 4'd0, 1'b0, w_zero, "dec_nop");
      add_fetch(4'd0, 1'b0);
      add(1'b0, 4'd1, 1'b0, w_zero, "dec_ldac");
      add(1'b0, 4'd1, 1'b0, mk(1'b1, 5'd1, RD_R, ALU_PASS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "ldac_s0");
      add(1'b0, 4'd1, 1'b0, w_f2, "ldac_s1");
      add(1'b0, 4'd1, 1'b0, mk(1'b1, 5'd2, RD_MIDR, ALU_PASS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "ldac_s2");
      add_fetch(4'd1, 1'b0);
      add(1'b0, 4'd2, 1'b0, w_zero, "dec_stac");
      add(1'b0, 4'd2, 1'b0, mk(1'b1, 5'd1, RD_R, ALU_PASS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "stac_s0");
      add(1'b0, 4'd2, 1'b0, mk(1'b0, 5'd0, RD_AC, ALU_PASS, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "stac_s1");
      add_fetch(4'd2, 1'b0);
      add(1'b0, 4'd3, 1'b0, w_zero, "dec_mvr");
      add(1'b0, 4'd3, 1'b0, mk(1'b1, 5'd3, RD_AC, ALU_PASS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "mvr");
      add_fetch(4'd3, 1'b0);
      add(1'b0, 4'd4, 1'b0, w_zero, "dec_add");
      add(1'b0, 4'd4, 1'b0, mk(1'b1, 5'd2, RD_ALU, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "add");
      add_fetch(4'd4, 1'b0);
      add(1'b0, 4'd5, 1'b0, w_zero, "dec_sub");
      add(1'b0, 4'd5, 1'b0, mk(1'b1, 5'd2, RD_ALU, ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "sub");
      add_fetch(4'd5, 1'b0);
      add(1'b0, 4'd6, 1'b0, w_zero, "dec_inc");
      add(1'b0, 4'd6, 1'b0, mk(1'b1, 5'd2, RD_ALU, ALU_INC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "inc");
      add_fetch(4'd6, 1'b0);
      add(1'b0, 4'd8, 1'b0, w_zero, "dec_jmp");
      add(1'b0, 4'd8, 1'b0, mk(1'b1, 5'd0, RD_R, ALU_PASS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "jmp");
      add_fetch(4'd8, 1'b0);
      add(1'b0, 4'd7, 1'b0, w_zero, "dec_jpnz");
      add(1'b0, 4'd7, 1'b0, mk(1'b1, 5'd0, RD_R, ALU_PASS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "jpnz_taken");
      add_fetch(4'd7, 1'b1);
      add(1'b0, 4'd7, 1'b1, w_zero, "dec_jpnz2");
      add(1'b0, 4'd7, 1'b1, w_zero, "jpnz_not_taken");
      add_fetch(4'd7, 1'b0);
      add(1'b0, 4'd15, 1'b0, w_zero, "dec_end");
      add(1'b0, 4'd15, 1'b0, w_done, "halt0");
      add(1'b0, 4'd15, 1'b0, w_done, "halt1");
      add(1'b1, 4'd15, 1'b0, w_done, "halt_start");
      add(1'b0, 4'd15, 1'b0, w_f1, "resume_f1");
      add(1'b0, 4'd15, 1'b0, w_f2, "resume_f2");
      add(1'b0, 4'd15, 1'b0, w_f3, "resume_f3");
      add(1'b0, 4'd12, 1'b0, w_zero, "dec_op12");
`ifdef IAAA_ILLEGAL_TRAP_EN
      add(1'b0, 4'd12, 1'b0, mk(1'b0, 5'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), "trap0");
      add(1'b1, 4'd12, 1'b0, mk(1'b0, 5'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), "trap_start");
      add(1'b0, 4'd12, 1'b0, w_f1, "trap_resume");
`else
      add(1'b0, 4'd12, 1'b0, w_f1, "op12_as_nop");
      add(1'b0, 4'd12, 1'b0, w_f2, "op12_f2");
`endif

      Reset_n = 1'b0; Start = 1'b0; IR_out = 4'd0; Z = 1'b0;
      #3;
      check("rst_hold", outs(), w_zero);
      @(posedge Clock);
      @(posedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;

      foreach (vq[i]) begin
         @(negedge Clock);
         Start  = vq[i].start;
         IR_out = vq[i].ir;
         Z      = vq[i].z;
         #1;
         check(vq[i].name, outs(), vq[i].exp);
      end

      // Reset asserted mid-F2 clears outputs immediately and stays idle afterwards.
      @(negedge Clock);
      Reset_n = 1'b0; Start = 1'b0; IR_out = 4'd0; Z = 1'b0;
      @(negedge Clock);
      Reset_n = 1'b1;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      @(negedge Clock);
      #1;
      check("pre_rst_f2", outs(), w_f2);
      #1;
      Reset_n = 1'b0;
      #1;
      check("rst_async", outs(), w_zero);
      @(negedge Clock);
      Reset_n = 1'b1;
      @(negedge Clock);
      #1;
      check("idle_after_rst0", outs(), w_zero);
      @(negedge Clock);
      #1;
      check("idle_after_rst1", outs(), w_zero);

      // END: Done must appear in the fifth cycle counted from F1.
      IR_out = 4'd15;
      Start  = 1'b1;
      cyc = 0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge Clock);
         Start = 1'b0;
         cyc++;
         #1;
         if (Done) seen = 1'b1;
      end
      checks++;
      if (!seen || cyc != 5) begin
         fails++;
         $display("FAIL end_latency: done_seen=%0d cycle=%0d required cycle=5", seen, cyc);
      end
      @(negedge Clock);
      #1;
      check("end_held", outs(), w_done);
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      #1;
      check("end_restart_f1", outs(), w_f1);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Fetch/decode/execute sequencer of the IAAA processor, directly downstream of the instruction register. It consumes the 4-bit opcode held in the IR and emits the per-cycle control word for the datapath. The control word comprises the write-decoder code, read-bus select, ALU operation and memory strobes. It also produces the write that loads the IR itself, closing the fetch loop.

## Interface
- No parameters; widths fixed by `iaaa_pkg`.
- `Clock` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Start` in 1: begin or resume execution; level-sampled.
- `IR_out` in 4: current opcode from the IR.
- `Z` in 1: ALU zero flag, registered upstream.
- `WR_en` out 1: write strobe to the write decoder.
- `WR_code` out 5: destination register code; 19 = IR, 31 = broadcast.
- `RD_sel` out 4: read-bus source select.
- `ALU_op` out 3: ALU operation.
- `PC_inc` out 1: increment PC this cycle.
- `Mem_rd` out 1: memory read; data lands in MIDR at the next edge.
- `Mem_wr` out 1: memory write of the bus value to `mem[AR]`.
- `Done` out 1: high while halted after END.
- `Illegal` out 1: see Configuration.

## Operation
- States: IDLE, F1, F2, F3, DEC, EXEC, HALT. EXEC uses a 2-bit step counter `step`.
- Registers are PC, AR, AC, R, MIDR and IR.
- **IDLE:** all strobes 0. `Start`=1 moves to F1.
- **F1:** RD=PC, WR AR, `PC_inc`=1.
- **F2:** `Mem_rd`=1.
- **F3:** RD=MIDR, WR IR (`WR_code`=19).
- **DEC:** no strobes. Branches on `IR_out` to EXEC with `step`=0, or to F1 for opcodes with no exec steps.
- Opcode sequences, one step per cycle; the last step returns to F1:
  - NOP (0): no exec steps; DEC goes to F1.
  - LDAC (1): RD=R, WR AR → `Mem_rd` → RD=MIDR, WR AC.
  - STAC (2): RD=R, WR AR → RD=AC, `Mem_wr`.
  - MVR (3): RD=AC, WR R.
  - ADD (4), SUB (5), INC (6): RD=ALU, `ALU_op`=ADD/SUB/INC, WR AC.
  - JMP (8): RD=R, WR PC.
  - JPNZ (7): if `Z`=0, RD=R, WR PC; otherwise no strobes. Takes 1 step either way.
  - END (15): DEC goes to HALT.
- **HALT:** `Done`=1. `Start`=1 moves to F1; PC is preserved.
- **Undefined opcodes (9–14):** behaviour per Configuration.
- Outputs are decoded combinationally from registered state, `step`, `IR_out` and `Z` only. No combinational input-to-output path from `Start`.
- At most one of `WR_en`, `Mem_wr` is asserted with a given bus source per cycle. `Mem_rd` and `Mem_wr` are never asserted together.

## Timing
- Reset (async assert, sync release) forces IDLE and `step`=0. All outputs read 0 during and after reset until state leaves IDLE.
- Instruction cost is 4 cycles (F1–DEC) plus exec steps:
  - NOP = 4 cycles.
  - MVR, ADD, SUB, INC, JMP, JPNZ = 5 cycles.
  - STAC = 6 cycles.
  - LDAC = 7 cycles.
- IR is written at the F3→DEC edge; `IR_out` is valid in DEC.
- `Start` is ignored outside IDLE and HALT.
- Reset mid-instruction abandons it. Partial writes already committed are not undone.

## Configuration
- **`IAAA_ILLEGAL_TRAP_EN` defined:** opcodes 9–14 in DEC go to HALT with `Illegal`=1. `Illegal` holds with `Done` until `Start` or reset.
- **Macro undefined:** opcodes 9–14 execute as NOP. `Illegal` is tied to 0.

## Structure
- `iaaa_pkg` holds:
  - opcode constants;
  - register codes: PC=0, AR=1, AC=2, R=3, MIDR=18, IR=19, ALL=31;
  - RD source codes, including ALU;
  - ALU op encodings;
  - the state enum.
- Sub-module `ctrl_decode`: purely combinational; maps (state, `step`, `IR_out`, `Z`) to the control word. `ctrl_unit` holds only the state and step registers.

## Test plan
- **Reset:** assert `Reset_n`=0 mid-F2 → outputs 0 immediately; state IDLE; after release no strobes until `Start`.
- **NOP fetch:** `Start` pulse, memory returns opcode 0 → F1 `PC_inc`=1 with WR AR; F3 `WR_code`=19; next F1 exactly 4 cycles after the first.
- **LDAC:** `IR_out`=1, R=0x0040, mem[0x40]=0x1234 → `Mem_rd` in exec step 1; AC=0x1234 at cycle 7; next fetch follows.
- **JPNZ:** `IR_out`=7 with `Z`=0 → WR PC in 5th cycle; with `Z`=1 → no `WR_en` in that cycle.
- **END:** `IR_out`=15 → `Done`=1 from cycle 5, held. `Start` → F1 next cycle, `Done`=0.
- **Opcode 12:** with `IAAA_ILLEGAL_TRAP_EN` → HALT, `Illegal`=1; without the macro → behaves as NOP, `Illegal`=0.
